// File: rtl/coin_change_dispenser.sv
// Change payout engine: validates a BCD change request and pays it out greedily
// (25c, 10c, 5c) through a 4-phase coin_req/coin_ack handshake.
module coin_change_dispenser #(
    parameter int MAX_CHANGE  = 35,
    parameter int ACK_TIMEOUT = 1000,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] change_bcd,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic [2:0] coin_sel,
    output logic [7:0] remaining_bcd,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [6:0]    MAX_BIN  = 7'(MAX_CHANGE);

    typedef enum logic [2:0] {IDLE, LOAD, SELECT, REQ, RELEASE, GAP, DONE, FAULT} state_t;

    state_t        state, state_d;
    logic          start_q;
    logic [7:0]    cap;
    logic [6:0]    remaining, remaining_d, coin_val, cap_bin;
    logic [TW-1:0] tmo, tmo_d;
    logic [GW-1:0] gap, gap_d;
    logic          coin_req_d, busy_d, done_d, error_d, valid;
    logic [2:0]    coin_sel_d;
    logic [7:0]    remaining_bcd_d;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    always_comb begin
        cap_bin = 7'(cap[7:4]) * 7'd10 + 7'(cap[3:0]);
        valid   = (cap[7:4] <= 4'd9) && (cap[3:0] == 4'd0 || cap[3:0] == 4'd5) &&
                  (cap_bin <= MAX_BIN);
        case (coin_sel)
            3'b100:  coin_val = 7'd25;
            3'b010:  coin_val = 7'd10;
            3'b001:  coin_val = 7'd5;
            default: coin_val = 7'd0;
        endcase
    end

    always_comb begin
        state_d         = state;
        remaining_d     = remaining;
        remaining_bcd_d = remaining_bcd;
        tmo_d           = tmo;
        gap_d           = gap;
        coin_req_d      = coin_req;
        coin_sel_d      = coin_sel;
        error_d         = error;
        done_d          = 1'b0;
        case (state)
            IDLE: begin
                if (start_q) begin
                    error_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!valid) begin
                    error_d         = 1'b1;
                    remaining_bcd_d = 8'h00;
                    state_d         = IDLE;
                end else begin
                    remaining_d     = cap_bin;
                    remaining_bcd_d = cap;
                    state_d         = SELECT;
                end
            end
            SELECT: begin
                if (remaining == 7'd0) begin
                    done_d          = 1'b1;
                    remaining_bcd_d = 8'h00;
                    state_d         = DONE;
                end else begin
                    coin_req_d = 1'b1;
                    coin_sel_d = (remaining >= 7'd25) ? 3'b100 :
                                 (remaining >= 7'd10) ? 3'b010 : 3'b001;
                    tmo_d      = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (coin_ack) begin
                    coin_req_d      = 1'b0;
                    coin_sel_d      = 3'b000;
                    remaining_d     = remaining - coin_val;
                    remaining_bcd_d = to_bcd(remaining - coin_val);
                    state_d         = RELEASE;
                end else if (tmo == TMO_LAST) begin
                    coin_req_d = 1'b0;
                    coin_sel_d = 3'b000;
                    error_d    = 1'b1;
                    state_d    = FAULT;
                end else begin
                    tmo_d = tmo + 1'b1;
                end
            end
            RELEASE: begin
                if (!coin_ack) begin
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? SELECT : GAP;
                end
            end
            GAP: begin
                if (gap == GAP_LAST) state_d = SELECT;
                else                 gap_d   = gap + 1'b1;
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) && (state_d != FAULT);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            cap           <= 8'h00;
            remaining     <= 7'd0;
            remaining_bcd <= 8'h00;
            tmo           <= '0;
            gap           <= '0;
            coin_req      <= 1'b0;
            coin_sel      <= 3'b000;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            // start is registered once here, so a request is only taken in IDLE
            if (state == IDLE && !start_q && start) begin
                start_q <= 1'b1;
                cap     <= change_bcd;
            end else begin
                start_q <= 1'b0;
            end
            state         <= state_d;
            remaining     <= remaining_d;
            remaining_bcd <= remaining_bcd_d;
            tmo           <= tmo_d;
            gap           <= gap_d;
            coin_req      <= coin_req_d;
            coin_sel      <= coin_sel_d;
            busy          <= busy_d;
            done          <= done_d;
            error         <= error_d;
        end
    end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser: expected coins/done pulses go into a
// scoreboard queue and a negedge monitor pops and compares them as they appear.
module tb_coin_change_dispenser;

    localparam int ACK_TIMEOUT = 1000;
    localparam int GAP_CYCLES  = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic [7:0] change_bcd = 8'h00;
    logic       coin_ack = 1'b0;
    logic       coin_req;
    logic [2:0] coin_sel;
    logic [7:0] remaining_bcd;
    logic       busy, done, error;

    coin_change_dispenser #(.MAX_CHANGE(35), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .clr(clr), .start(start), .change_bcd(change_bcd), .coin_ack(coin_ack),
        .coin_req(coin_req), .coin_sel(coin_sel), .remaining_bcd(remaining_bcd),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_done; logic [2:0] sel; logic [7:0] bcd; } exp_t;
    exp_t exp_q[$];
    int   req_times[$], fall_times[$], done_times[$], ackfall_times[$];
    int   cyc = 0;
    int   n_checks = 0, n_pass = 0;
    bit   ack_en = 1'b1;
    bit   prev_req = 1'b0, prev_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int cnt(input int which);
        case (which)
            0:       return req_times.size();
            1:       return fall_times.size();
            2:       return done_times.size();
            default: return ackfall_times.size();
        endcase
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (coin_req && !prev_req) begin
            req_times.push_back(cyc);
            if (exp_q.size() == 0) check(1'b0, "unexpected_coin", int'(coin_sel), 0);
            else begin
                e = exp_q.pop_front();
                check(!e.is_done && e.sel == coin_sel && e.bcd == remaining_bcd, "coin_sel_bcd",
                      int'({coin_sel, remaining_bcd}), int'({e.sel, e.bcd}));
            end
        end
        if (!coin_req && prev_req) fall_times.push_back(cyc);
        if (!coin_ack && prev_ack) ackfall_times.push_back(cyc);
        if (done) begin
            done_times.push_back(cyc);
            if (exp_q.size() == 0) check(1'b0, "unexpected_done", int'(remaining_bcd), 0);
            else begin
                e = exp_q.pop_front();
                check(e.is_done && remaining_bcd == 8'h00, "done_event",
                      int'({e.is_done, remaining_bcd}), 256);
            end
        end
        prev_req = coin_req;
        prev_ack = coin_ack;
    end

    // coin mechanism: acks two cycles after seeing a request, releases after req drops
    initial begin
        forever begin
            @(negedge clk);
            if (coin_req && ack_en) begin
                repeat (2) @(posedge clk);
                #1 coin_ack = 1'b1;
                for (int i = 0; i < 50 && coin_req; i++) @(negedge clk);
                @(posedge clk);
                #1 coin_ack = 1'b0;
            end
        end
    end

    function automatic void exp_coin(input logic [2:0] sel, input logic [7:0] bcd);
        exp_t e;
        e.is_done = 1'b0; e.sel = sel; e.bcd = bcd;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_done();
        exp_t e;
        e.is_done = 1'b1; e.sel = 3'b000; e.bcd = 8'h00;
        exp_q.push_back(e);
    endfunction

    task automatic pulse_start(input logic [7:0] v, output int sc);
        @(posedge clk);
        #1 change_bcd = v; start = 1'b1; sc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_for(input string name, input int which, input int target, input int budget);
        for (int i = 0; i < budget && cnt(which) < target; i++) @(negedge clk);
        if (cnt(which) < target) check(1'b0, {name, "_timeout"}, cnt(which), target);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(coin_req == 1'b0 && coin_sel == 3'b000, {tag, "_coin"}, int'({coin_req, coin_sel}), 0);
        check(remaining_bcd == 8'h00, {tag, "_bcd"}, int'(remaining_bcd), 0);
        check(busy == 1'b0 && done == 1'b0 && error == 1'b0, {tag, "_status"},
              int'({busy, done, error}), 0);
    endtask

    initial begin
        int sc, dummy, br, bd, ba, bf;
        logic [7:0] bad [3];
        bad = '{8'h17, 8'h40, 8'h3A};

        // reset
        settle(3);
        check_reset_outputs("reset");
        clr = 1'b0;
        settle(2);

        // 35 -> 25 then 10
        br = cnt(0); bd = cnt(2);
        exp_coin(3'b100, 8'h35); exp_coin(3'b010, 8'h10); exp_done();
        pulse_start(8'h35, sc);
        wait_for("done35", 2, bd + 1, 200);
        settle(1);
        check(cnt(0) > br && req_times[br] - sc == 4, "req_latency",
              (cnt(0) > br) ? req_times[br] - sc : -1, 4);
        check(cnt(0) == br + 2, "coins35", cnt(0) - br, 2);
        check(busy == 1'b0 && error == 1'b0 && remaining_bcd == 8'h00, "after35",
              int'({busy, error, remaining_bcd}), 0);

        // 30 -> 25 then 5, with gap timing; the RELEASE edge that samples ack low,
        // then GAP_CYCLES of GAP, then SELECT, before the next request edge
        br = cnt(0); bd = cnt(2); ba = cnt(3);
        exp_coin(3'b100, 8'h30); exp_coin(3'b001, 8'h05); exp_done();
        pulse_start(8'h30, sc);
        wait_for("done30", 2, bd + 1, 200);
        settle(1);
        check(cnt(0) > br + 1 && cnt(3) > ba && req_times[br + 1] - ackfall_times[ba] == GAP_CYCLES + 2,
              "gap_cycles", (cnt(0) > br + 1 && cnt(3) > ba) ? req_times[br + 1] - ackfall_times[ba] : -1,
              GAP_CYCLES + 2);

        // zero change
        br = cnt(0); bd = cnt(2);
        exp_done();
        pulse_start(8'h00, sc);
        wait_for("done00", 2, bd + 1, 50);
        settle(1);
        check(cnt(2) > bd && done_times[bd] - sc == 4, "zero_done_latency",
              (cnt(2) > bd) ? done_times[bd] - sc : -1, 4);
        check(cnt(0) == br && error == 1'b0, "zero_no_coin", cnt(0) - br, 0);

        // invalid requests
        foreach (bad[k]) begin
            br = cnt(0); bd = cnt(2);
            pulse_start(bad[k], sc);
            settle(8);
            check(error == 1'b1, "invalid_error", int'(error), 1);
            check(cnt(0) == br && cnt(2) == bd && busy == 1'b0 && remaining_bcd == 8'h00,
                  "invalid_quiet", int'({busy, remaining_bcd}), 0);
        end
        br = cnt(0); bd = cnt(2);
        exp_coin(3'b010, 8'h10); exp_done();
        pulse_start(8'h10, sc);
        wait_for("done10", 2, bd + 1, 200);
        settle(1);
        check(error == 1'b0 && cnt(0) == br + 1, "valid_after_invalid",
              int'(error) * 16 + cnt(0) - br, 1);

        // ack timeout
        ack_en = 1'b0;
        br = cnt(0); bf = cnt(1);
        exp_coin(3'b010, 8'h15);
        pulse_start(8'h15, sc);
        wait_for("req15", 0, br + 1, 20);
        wait_for("fall15", 1, bf + 1, ACK_TIMEOUT + 100);
        check(cnt(0) > br && cnt(1) > bf && fall_times[bf] - req_times[br] == ACK_TIMEOUT,
              "timeout_len", (cnt(0) > br && cnt(1) > bf) ? fall_times[bf] - req_times[br] : -1,
              ACK_TIMEOUT);
        settle(1);
        check(error == 1'b1 && busy == 1'b0 && coin_req == 1'b0, "fault_status",
              int'({error, busy, coin_req}), 4);
        check(remaining_bcd == 8'h15, "fault_bcd", int'(remaining_bcd), 8'h15);
        pulse_start(8'h05, dummy);
        settle(10);
        check(cnt(0) == br + 1 && remaining_bcd == 8'h15 && error == 1'b1 && busy == 1'b0,
              "fault_ignores_start", int'({busy, error, remaining_bcd}), int'({2'b01, 8'h15}));
        clr = 1'b1;
        #2;
        check_reset_outputs("fault_clr");
        settle(1);
        clr = 1'b0;
        ack_en = 1'b1;
        settle(2);

        // async clear mid-handshake
        ack_en = 1'b0;
        br = cnt(0);
        exp_coin(3'b100, 8'h25);
        pulse_start(8'h25, sc);
        wait_for("req25", 0, br + 1, 20);
        #2 clr = 1'b1;
        #1;
        check_reset_outputs("async_clr");
        @(posedge clk);
        #1 clr = 1'b0;
        ack_en = 1'b1;
        settle(2);

        // stray start during payout of 20
        br = cnt(0); bd = cnt(2);
        exp_coin(3'b010, 8'h20); exp_coin(3'b010, 8'h10); exp_done();
        pulse_start(8'h20, sc);
        wait_for("req20", 0, br + 1, 20);
        pulse_start(8'h35, dummy);
        wait_for("done20", 2, bd + 1, 200);
        settle(10);
        check(cnt(0) == br + 2 && cnt(2) == bd + 1, "busy_ignores_start",
              cnt(0) - br, 2);
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck, expected finish");
        $fatal(1);
    end

endmodule
